// File: rtl/mux_pkg.sv
// mux_pkg: shared mode constants and select-width helper for the stream mux
package mux_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr with wrap
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [SEL_W-1:0]    i_ptr,
  input  logic                i_en,
  output logic [CHANNELS-1:0] o_gnt,
  output logic [SEL_W-1:0]    o_idx
);
  logic w_found;
  int   w_c;
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_c     = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_c = int'(i_ptr) + k;
      w_c = (w_c >= CHANNELS) ? w_c - CHANNELS : w_c;
      if (i_en && !w_found && w_c < CHANNELS && i_req[w_c]) begin
        w_found    = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = SEL_W'(w_c);
      end
    end
  end
endmodule

// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: N:1 valid/ready stream mux with a single registered output
// stage, fixed-select or round-robin arbitration.
module mux_nto1_stream
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int RR_MODE  = 1,
  localparam int SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);
  logic [CHANNELS-1:0] w_gnt;
  logic [SEL_W-1:0]    w_idx;
  logic [WIDTH-1:0]    w_mux;
  logic                w_load_en;
  logic                w_accept;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_chan;
  logic [SEL_W-1:0]    r_ptr;
  logic                r_valid;

  // Grants are masked during reset so in_ready stays low while rst_n is low.
  if (RR_MODE == MODE_RR) begin : g_rr
    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
      .i_req(in_valid),
      .i_ptr(r_ptr),
      .i_en (rst_n),
      .o_gnt(w_gnt),
      .o_idx(w_idx)
    );
  end else begin : g_fix
    localparam int PAD = 1 << SEL_W;
    logic [PAD-1:0] w_vpad;
    logic [PAD-1:0] w_gpad;
    // Zero padding makes out-of-range sel values grant nothing.
    always_comb begin
      w_vpad         = PAD'(in_valid);
      w_gpad         = '0;
      w_gpad[sel]    = rst_n & w_vpad[sel];
      w_gnt          = w_gpad[CHANNELS-1:0];
      w_idx          = sel;
    end
  end

  always_comb begin
    w_mux = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (w_gnt[i]) w_mux = in_data[i*WIDTH +: WIDTH];
  end

  assign w_load_en = !r_valid || out_ready;
  assign in_ready  = w_gnt & {CHANNELS{w_load_en}};
  assign w_accept  = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (w_load_en) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_data <= w_mux;
        r_chan <= w_idx;
        r_ptr  <= (int'(w_idx) == CHANNELS - 1) ? '0 : w_idx + SEL_W'(1);
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_chan  = r_chan;
endmodule

// File: tb/tb_mux_nto1_stream.sv
// tb_mux_nto1_stream: three instances (4ch RR, 4ch fixed, 3ch RR) driven by
// shared stimulus and checked against per-instance behavioural models.
module tb_mux_nto1_stream;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel;
  logic        out_ready;
  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy2;
  logic [7:0]  od [3];
  logic        ov [3];
  logic [1:0]  oc [3];

  int errors = 0;
  int checks = 0;

  bit       mv [3];
  logic [7:0] md [3];
  int       mc [3];
  int       mp [3];

  always #5 clk = ~clk;

  mux_nto1_stream #(.WIDTH(8), .CHANNELS(4), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .sel(sel), .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .out_chan(oc[0]));
  mux_nto1_stream #(.WIDTH(8), .CHANNELS(4), .RR_MODE(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .sel(sel), .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .out_chan(oc[1]));
  mux_nto1_stream #(.WIDTH(8), .CHANNELS(3), .RR_MODE(1)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]),
    .in_ready(rdy2), .sel(sel), .out_data(od[2]), .out_valid(ov[2]),
    .out_ready(out_ready), .out_chan(oc[2]));

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  function automatic logic [3:0] rdy_of(input int d);
    return (d == 0) ? rdy0 : (d == 1) ? rdy1 : {1'b0, rdy2};
  endfunction

  // Reference: which channel the spec says is accepted this cycle, or -1.
  function automatic int m_gnt(input int d);
    int n;
    n = (d == 2) ? 3 : 4;
    if (!rst_n || (mv[d] && !out_ready)) return -1;
    if (d == 1) return (int'(sel) < n && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 0; k < n; k++)
      if (in_valid[(mp[d] + k) % n]) return (mp[d] + k) % n;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mv[d] = 0; md[d] = 8'h00; mc[d] = 0; mp[d] = 0;
    end
  endtask

  task automatic check_outs(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_valid"}, d, 32'(ov[d]), 32'(mv[d]));
      chk({tag, "_data"},  d, 32'(od[d]), 32'(md[d]));
      chk({tag, "_chan"},  d, 32'(oc[d]), mc[d]);
    end
  endtask

  task automatic step();
    int g [3];
    int n;
    #1;
    for (int d = 0; d < 3; d++) begin
      g[d] = m_gnt(d);
      chk("in_ready", d, 32'(rdy_of(d)), (g[d] < 0) ? 32'd0 : (32'd1 << g[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      n = (d == 2) ? 3 : 4;
      if (!rst_n) begin
        mv[d] = 0; md[d] = 0; mc[d] = 0; mp[d] = 0;
      end else if (g[d] >= 0) begin
        mv[d] = 1; md[d] = in_data[g[d]*8 +: 8]; mc[d] = g[d]; mp[d] = (g[d] + 1) % n;
      end else if (!mv[d] || out_ready) begin
        mv[d] = 0;
      end
    end
    #1;
    check_outs("post");
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs("rst");
    chk("rst_rdy", 0, 32'(rdy0), 0);
    chk("rst_rdy", 1, 32'(rdy1), 0);
    chk("rst_rdy", 2, 32'(rdy2), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int exp_rr [6] = '{0, 1, 2, 3, 0, 1};
  int exp_r3 [6] = '{0, 1, 2, 0, 1, 2};
  logic [7:0] held_d;
  int held_c;

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '0; sel = '0; out_ready = 1'b0;
    model_reset();
    #3;
    check_outs("init");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All channels valid, fixed select on ch2, RR fairness
    in_data = 32'h4332_2110; in_valid = 4'hf; sel = 2'd2; out_ready = 1'b1;
    #1 chk("fx_rdy_sel2", 1, 32'(rdy1), 32'h4);
    step();
    chk("fx_data_sel2", 1, 32'(od[1]), 32'h32);
    chk("fx_chan_sel2", 1, 32'(oc[1]), 2);
    chk("rr_seq", 0, 32'(oc[0]), exp_rr[0]);
    chk("rr3_seq", 2, 32'(oc[2]), exp_r3[0]);
    for (int i = 1; i < 6; i++) begin
      step();
      chk("rr_seq", 0, 32'(oc[0]), exp_rr[i]);
      chk("rr3_seq", 2, 32'(oc[2]), exp_r3[i]);
    end

    // Fixed select on an idle channel
    sel = 2'd3; in_valid = 4'b0111;
    step();
    chk("fx_idle_valid", 1, 32'(ov[1]), 0);

    // Back-pressure: hold for three cycles, then reload with no bubble
    in_valid = 4'hf; sel = 2'd1;
    step();
    held_d = od[0]; held_c = int'(oc[0]);
    out_ready = 1'b0;
    repeat (3) step();
    chk("bp_hold_data", 0, 32'(od[0]), 32'(held_d));
    chk("bp_hold_chan", 0, 32'(oc[0]), held_c);
    out_ready = 1'b1;
    step();
    chk("bp_nobubble", 0, 32'(ov[0]), 1);
    chk("bp_next_chan", 0, 32'(oc[0]), (held_c + 1) % 4);

    // Sparse requests starting from ptr=2
    async_reset();
    in_valid = 4'b0010;
    step();
    in_valid = 4'b1010;
    step();
    chk("sparse_first", 0, 32'(oc[0]), 3);
    step();
    chk("sparse_second", 0, 32'(oc[0]), 1);

    // Reset mid-stream, then arbitration restarts at ch0
    in_valid = 4'hf;
    repeat (2) step();
    chk("mid_valid", 0, 32'(ov[0]), 1);
    async_reset();
    step();
    chk("restart_ch0", 0, 32'(oc[0]), 0);
    chk("restart_ch0", 2, 32'(oc[2]), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom_range(0, 15));
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
